his_builder_fsm: RTL and testbench

Per-pixel time-of-flight histogram builder with streaming peak detection. It accepts a serial stream of Np-bit TDC timestamps for PIXEL_NUM_PER_RAM pixels and bins them into one coarse histogram per pixel, over ACQ_NUM acquisitions per frame. At the end of each frame it publishes the peak bin of every pixel on `peakResult`, then clears itself for the next frame. It sits between the TDC/readout stream and the depth-estimation stage.

---
 rtl/his_builder_fsm.sv | 130 +++++++++++++
 tb/tb_his_builder_fsm.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/his_builder_fsm.sv
// Per-pixel coarse time-of-flight histogram builder with streaming peak tracking.
// Each completed frame publishes every pixel's peak bin and then clears the histograms.
module his_builder_fsm #(
  parameter int Np                = 10,
  parameter int PIXEL_NUM_PER_RAM = 3,
  parameter int ACQ_NUM           = 2,
  parameter int DATA_NUM          = 2,
  parameter int BIN_BITS          = 5,
  parameter int CNT_W             = 8
) (
  input  logic          clk,
  input  logic          res,
  input  logic          wrEn,
  input  logic [Np-1:0] data,
  output logic [Np-1:0] peakResult [PIXEL_NUM_PER_RAM],
  output logic          stateDbg
);

  // valid/ready: there is no ready; a sample is consumed on every rising edge with wrEn high.

  localparam int SMP_W   = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int PIX_W   = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;
  localparam int ACQ_W   = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam int NUM_BIN = 1 << BIN_BITS;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t state, stateNext;

  logic [SMP_W-1:0]    smp;
  logic [PIX_W-1:0]    pix;
  logic [ACQ_W-1:0]    acq;
  logic [CNT_W-1:0]    hist   [PIXEL_NUM_PER_RAM][NUM_BIN];
  logic [CNT_W-1:0]    maxCnt [PIXEL_NUM_PER_RAM];
  logic [BIN_BITS-1:0] maxBin [PIXEL_NUM_PER_RAM];
  logic [BIN_BITS-1:0] binNext[PIXEL_NUM_PER_RAM];

  logic                accept;
  logic                hit;
  logic                lastSmp, lastPix, lastAcq;
  logic                frameEnd;
  logic [BIN_BITS-1:0] bin;
  logic [CNT_W-1:0]    curCnt;
  logic [CNT_W-1:0]    newCnt;

  // State register
  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state logic: samples are accepted in both states, IDLE only marks "nothing seen yet"
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (wrEn) stateNext = ACCUM;
      ACCUM:   stateNext = ACCUM;
      default: stateNext = IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    accept   = wrEn;
    hit      = wrEn && (data != '0);
    lastSmp  = (smp == SMP_W'(DATA_NUM - 1));
    lastPix  = (pix == PIX_W'(PIXEL_NUM_PER_RAM - 1));
    lastAcq  = (acq == ACQ_W'(ACQ_NUM - 1));
    frameEnd = accept && lastSmp && lastPix && lastAcq;
    stateDbg = state;
  end

  assign bin    = data[Np-1 -: BIN_BITS];
  assign curCnt = hist[pix][bin];
  assign newCnt = (curCnt == {CNT_W{1'b1}}) ? curCnt : curCnt + 1'b1;

  // Tracker values including the current sample, so the publish sees the frame's last hit
  always_comb begin
    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
      binNext[p] = maxBin[p];
      if (hit && (pix == PIX_W'(p)) && (newCnt > maxCnt[p])) binNext[p] = bin;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      smp <= '0;
      pix <= '0;
      acq <= '0;
    end else if (accept) begin
      if (lastSmp) begin
        smp <= '0;
        if (lastPix) begin
          pix <= '0;
          acq <= lastAcq ? '0 : acq + 1'b1;
        end else begin
          pix <= pix + 1'b1;
        end
      end else begin
        smp <= smp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
        for (int b = 0; b < NUM_BIN; b++) hist[p][b] <= '0;
        maxCnt[p]     <= '0;
        maxBin[p]     <= '0;
        peakResult[p] <= '0;
      end
    end else if (frameEnd) begin
      for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
        for (int b = 0; b < NUM_BIN; b++) hist[p][b] <= '0;
        maxCnt[p]     <= '0;
        maxBin[p]     <= '0;
        peakResult[p] <= {binNext[p], {(Np-BIN_BITS){1'b0}}};
      end
    end else if (hit) begin
      hist[pix][bin] <= newCnt;
      // Strictly greater: on a tie the bin that reached the count first keeps the peak
      if (newCnt > maxCnt[pix]) begin
        maxCnt[pix] <= newCnt;
        maxBin[pix] <= bin;
      end
    end
  end

endmodule

// File: tb/tb_his_builder_fsm.sv
// Directed bench for his_builder_fsm: frame vectors from a table plus reset corner sequences.
module tb_his_builder_fsm;

  localparam int NP  = 10;
  localparam int PIX = 3;
  localparam int LEN = 12;

  logic          clk;
  logic          res;
  logic          wrEn;
  logic [NP-1:0] data;
  logic [NP-1:0] peakResult [PIX];
  logic          stateDbg;

  typedef struct {
    logic [0:LEN-1][NP-1:0] samples;
    logic [0:PIX-1][NP-1:0] exp;
    bit                     gaps;
  } vec_t;

  vec_t vecs[5];
  logic [PIX*NP-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  his_builder_fsm dut (
    .clk        (clk),
    .res        (res),
    .wrEn       (wrEn),
    .data       (data),
    .peakResult (peakResult),
    .stateDbg   (stateDbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkPeaks(input string name, input logic [0:PIX-1][NP-1:0] exp);
    for (int p = 0; p < PIX; p++) begin
      checks++;
      if (peakResult[p] !== exp[p]) begin
        failures++;
        $display("FAIL %s pix%0d got=%0d exp=%0d", name, p, peakResult[p], exp[p]);
      end
    end
  endtask

  task automatic checkState(input string name, input logic exp);
    checks++;
    if (stateDbg !== exp) begin
      failures++;
      $display("FAIL %s state got=%0d exp=%0d", name, stateDbg, exp);
    end
  endtask

  // Driver: applies one full frame, checking hold before and publish on the last sample
  task automatic runFrame(input vec_t v, input logic [0:PIX-1][NP-1:0] prevExp, input string name);
    logic [PIX*NP-1:0] expPub;
    exp_q.push_back(v.exp);
    for (int i = 0; i < LEN; i++) begin
      if (v.gaps && i > 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int g = 0; g < n; g++) begin
          wrEn = 1'b0;
          data = NP'($urandom);
          @(posedge clk); #1;
        end
      end
      wrEn = 1'b1;
      data = v.samples[i];
      @(posedge clk); #1;
      if (i < LEN - 1) begin
        checkPeaks({name, "_hold"}, prevExp);
      end else begin
        expPub = exp_q.pop_front();
        checkPeaks({name, "_publish"}, expPub);
      end
    end
  endtask

  initial begin
    logic [0:PIX-1][NP-1:0] zeros;
    logic [0:PIX-1][NP-1:0] prev;
    zeros = '0;

    vecs[0].samples = {10'd108, 10'd511, 10'd1022, 10'd1022, 10'd200, 10'd90,
                       10'd100, 10'd600, 10'd1000, 10'd1023, 10'd120, 10'd90};
    vecs[0].exp     = {10'd96, 10'd992, 10'd64};
    vecs[0].gaps    = 1'b0;
    vecs[1].samples = {10'd300, 10'd500, 10'd0, 10'd0, 10'd48, 10'd48,
                       10'd0, 10'd0, 10'd0, 10'd0, 10'd90, 10'd90};
    vecs[1].exp     = {10'd288, 10'd0, 10'd32};
    vecs[1].gaps    = 1'b0;
    vecs[2]         = vecs[0];
    vecs[2].gaps    = 1'b1;
    vecs[3].samples = {10'd300, 10'd500, 10'd500, 10'd48, 10'd1000, 10'd50,
                       10'd300, 10'd1000, 10'd500, 10'd90, 10'd1000, 10'd600};
    vecs[3].exp     = {10'd288, 10'd480, 10'd992};
    vecs[3].gaps    = 1'b0;
    vecs[4]         = vecs[0];

    // Reset held low with live traffic
    res  = 1'b0;
    wrEn = 1'b1;
    data = NP'($urandom);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      data = NP'($urandom);
    end
    checkPeaks("reset", zeros);
    checkState("reset", 1'b0);
    wrEn = 1'b0;
    res  = 1'b1;
    @(posedge clk); #1;
    checkState("idle_no_wren", 1'b0);

    prev = zeros;
    for (int v = 0; v < 5; v++) begin
      runFrame(vecs[v], prev, $sformatf("vec%0d", v));
      if (v == 0) checkState("accum", 1'b1);
      prev = vecs[v].exp;
    end

    // Reset mid-frame: five samples in, then an asynchronous pulse
    for (int i = 0; i < 5; i++) begin
      wrEn = 1'b1;
      data = vecs[0].samples[i];
      @(posedge clk); #1;
    end
    wrEn = 1'b1;
    data = NP'($urandom);
    #1 res = 1'b0;
    #1;
    checkPeaks("midreset_async", zeros);
    checkState("midreset_async", 1'b0);
    @(posedge clk); #1;
    checkPeaks("midreset_held", zeros);
    wrEn = 1'b0;
    res  = 1'b1;
    @(posedge clk); #1;
    runFrame(vecs[1], zeros, "after_reset");
    wrEn = 1'b0;
    @(posedge clk); #1;
    checkPeaks("final_hold", vecs[1].exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
